sgmii_rx_adapt: RTL

SGMII_RX_ADAPT -- requirements
Module: sgmii_rx_adapt

---
 rtl/sgmii_rx_adapt_pkg.sv | 40 ++++
 rtl/sgmii_rate_strobe.sv | 43 ++++
 rtl/sgmii_rx_adapt.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sgmii_rx_adapt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sgmii_rx_adapt_pkg                                                   |
// | Shared SGMII code-groups, rate selects and adapter FSM states.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sgmii_rx_adapt_pkg;

  localparam logic [7:0] c_K28_5         = 8'hBC;
  localparam logic [7:0] c_K_S           = 8'hFB;
  localparam logic [7:0] c_K_T           = 8'hFD;
  localparam logic [7:0] c_K_R           = 8'hF7;
  localparam logic [7:0] c_K_V           = 8'hFE;
  localparam logic [7:0] c_PREAMBLE      = 8'h55;
  localparam logic [7:0] c_FALSE_CARRIER = 8'h0E;
  localparam logic [7:0] c_CARRIER_EXT   = 8'h0F;

  localparam logic [2:0] c_SPEED_1000 = 3'b100;
  localparam logic [2:0] c_SPEED_100  = 3'b010;
  localparam logic [2:0] c_SPEED_10   = 3'b001;

  typedef logic [1:0] rxState_t;
  localparam rxState_t c_ST_IDLE    = 2'd0;
  localparam rxState_t c_ST_RECEIVE = 2'd1;
  localparam rxState_t c_ST_EXTEND  = 2'd2;

  // Replication factor for a one-hot rate select; anything unrecognised is gigabit.
  function automatic logic [6:0] rateDivisor(input logic [2:0] speed,
                                             input logic [6:0] div100,
                                             input logic [6:0] div10);
    case (speed)
      c_SPEED_100:  return div100;
      c_SPEED_10:   return div10;
      c_SPEED_1000: return 7'd1;
      default:      return 7'd1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sgmii_rate_strobe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sgmii_rate_strobe                                                    |
// | Sample counter producing the 1-in-N GMII update strobe.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sgmii_rate_strobe
  import sgmii_rx_adapt_pkg::*;
#(
  parameter int DIV_100 = 10,
  parameter int DIV_10  = 100
) (
  input  logic       clk_125M,
  input  logic       rst,
  input  logic [2:0] speed,
  input  logic       hold,
  input  logic       align,
  output logic       ce
);

  logic [6:0] r_count;
  logic [6:0] w_last;

  assign w_last = rateDivisor(speed, 7'(DIV_100), 7'(DIV_10)) - 7'd1;

  // align treats the current cycle as count 0 so the next strobe lands N cycles later.
  assign ce = hold | align | (r_count == 7'd0);

  // Comparing with >= also clears a count stranded above a newly shortened period.
  always_ff @(posedge clk_125M) begin
    if (rst || hold) begin
      r_count <= 7'd0;
    end else if (align) begin
      r_count <= (w_last == 7'd0) ? 7'd0 : 7'd1;
    end else if (r_count >= w_last) begin
      r_count <= 7'd0;
    end else begin
      r_count <= r_count + 7'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sgmii_rx_adapt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sgmii_rx_adapt                                                       |
// | SGMII PCS receive octets to GMII RxD/RxDV/RxER with rate adaptation. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sgmii_rx_adapt
  import sgmii_rx_adapt_pkg::*;
#(
  parameter int DIV_100 = 10,
  parameter int DIV_10  = 100
) (
  input  logic       clk_125M,
  input  logic       rst,
  input  logic       rx_sync,
  input  logic [7:0] rx_data,
  input  logic       rx_k,
  input  logic       rx_cerr,
  input  logic [2:0] Speed,
  output logic [7:0] RxD,
  output logic       RxDV,
  output logic       RxER,
  output logic       rx_ce,
  output logic       false_carrier
);

  rxState_t   r_state;
  rxState_t   w_nextState;
  logic       w_ce;
  logic       w_align;
  logic       w_isS, w_isT, w_isR, w_isComma;
  logic [7:0] w_rxd;
  logic       w_rxdv, w_rxer, w_falseCarrier;

  assign w_isS     = rx_k && (rx_data == c_K_S);
  assign w_isT     = rx_k && (rx_data == c_K_T);
  assign w_isR     = rx_k && (rx_data == c_K_R);
  assign w_isComma = rx_k && (rx_data == c_K28_5);

  // A clean /S/ in IDLE starts a frame on whichever replica arrives first.
  assign w_align = rx_sync && !rx_cerr && w_isS && (r_state == c_ST_IDLE);

  sgmii_rate_strobe #(
    .DIV_100 (DIV_100),
    .DIV_10  (DIV_10)
  ) u_strobe (
    .clk_125M (clk_125M),
    .rst      (rst),
    .speed    (Speed),
    .hold     (!rx_sync),
    .align    (w_align),
    .ce       (w_ce)
  );

  always_ff @(posedge clk_125M) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else if (w_ce) begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (!rx_sync) begin
      w_nextState = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE:    if (w_align) w_nextState = c_ST_RECEIVE;
        c_ST_RECEIVE: begin
          if (!rx_cerr && w_isT)          w_nextState = c_ST_EXTEND;
          else if (!rx_cerr && w_isComma) w_nextState = c_ST_IDLE;
        end
        c_ST_EXTEND:  if (rx_cerr || !w_isR) w_nextState = c_ST_IDLE;
        default:      w_nextState = c_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rxd          = 8'h00;
    w_rxdv         = 1'b0;
    w_rxer         = 1'b0;
    w_falseCarrier = 1'b0;
    if (rx_sync) begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_align) begin
            w_rxd  = c_PREAMBLE;
            w_rxdv = 1'b1;
          end else if (rx_cerr || (rx_k && !w_isComma)) begin
            w_rxd          = c_FALSE_CARRIER;
            w_rxer         = 1'b1;
            w_falseCarrier = 1'b1;
          end
        end
        c_ST_RECEIVE: begin
          // Coding errors, /V/, stray K codes and an early comma all flag the sample.
          if (!rx_cerr && w_isT) begin
            w_rxd = 8'h00;
          end else begin
            w_rxd  = rx_data;
            w_rxdv = 1'b1;
            w_rxer = rx_cerr || rx_k;
          end
        end
        c_ST_EXTEND: begin
          if (rx_cerr || !w_isComma) begin
            w_rxd  = c_CARRIER_EXT;
            w_rxer = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_125M) begin
    if (rst) begin
      RxD           <= 8'h00;
      RxDV          <= 1'b0;
      RxER          <= 1'b0;
      rx_ce         <= 1'b0;
      false_carrier <= 1'b0;
    end else begin
      rx_ce         <= w_ce;
      false_carrier <= w_ce & w_falseCarrier;
      if (w_ce) begin
        RxD  <= w_rxd;
        RxDV <= w_rxdv;
        RxER <= w_rxer;
      end
    end
  end

endmodule
`default_nettype wire
